// File: rtl/bitop_rr_sched.sv
// Round-robin arbiter in front of one registered bitwise-logic unit.
// The granted result is held with its requester tag until the consumer accepts it.
module bitop_rr_sched #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [3*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [1:0]              out_tag,
  output logic [CNTW-1:0]         issue_count
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       tag_q, tag_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             can_accept;
  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic             xfer;
  logic [2:0]       op_g;
  logic [WIDTH-1:0] a_g, b_g;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    unique case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: r = a ^ b;
      3'b011: r = ~(a ^ b);
      3'b100: r = ~(a & b);
      3'b101: r = ~(a | b);
      3'b110: r = a & ~b;
      3'b111: r = a;
    endcase
    return r;
  endfunction

  // A full register being drained this cycle may be refilled in the same cycle.
  assign can_accept = (state_q == StEmpty) | out_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign xfer = grant_vld & can_accept & ~rst;
  assign op_g = req_op[3*grant_idx +: 3];
  assign a_g  = req_a[WIDTH*grant_idx +: WIDTH];
  assign b_g  = req_b[WIDTH*grant_idx +: WIDTH];

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      state_d = StFull;
      data_d  = logic_op(op_g, a_g, b_g);
      tag_d   = grant_idx;
      ptr_d   = grant_idx + 2'd1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (state_q == StFull && out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = (state_q == StFull);
  assign out_data    = data_q;
  assign out_tag     = tag_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_bitop_rr_sched.sv
// Scoreboard bench for bitop_rr_sched: directed stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result is consumed.
`timescale 1ns/1ps
module tb_bitop_rr_sched;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [11:0]   req_op;
  logic [31:0]   req_a;
  logic [31:0]   req_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_tag;
  logic [15:0]   issue_count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0]   tag;
    logic [W-1:0] data;
  } exp_t;
  exp_t sb_q[$];

  bitop_rr_sched #(.WIDTH(W), .NREQ(4), .CNTW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .issue_count (issue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a ^ b);
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_op[3*k +: 3] = op;
    req_a[W*k +: W]  = a;
    req_b[W*k +: W]  = b;
  endtask

  task automatic push(input logic [1:0] tag, input logic [W-1:0] data);
    exp_t e;
    e.tag  = tag;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Issue one request from requester k and wait (bounded) for its grant.
  task automatic send(input int k, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp);
    bit got = 0;
    set_req(k, op, a, b);
    req_valid[k] = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready[k]) got = 1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: requester %0d got no ready, expected grant", k);
    end else begin
      push(2'(k), exp);
    end
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got tag %0d data %0h, expected no result", out_tag,
                 out_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_data", 32'(out_data), 32'(e.data));
        chk("sb_tag", 32'(out_tag), 32'(e.tag));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sweep_exp [8];
    int           fair_g [6];
    logic [W-1:0] hold_data;
    sweep_exp = '{8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h3F, 8'h03, 8'h30, 8'hF0};
    fair_g    = '{0, 1, 2, 3, 0, 1};

    rst       = 1'b1;
    req_valid = 4'b1111;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_count", 32'(issue_count), 0);
    chk("rst_ready", 32'(req_ready), 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Opcode sweep from requester 2.
    for (int i = 0; i < 8; i++) send(2, 3'(i), 8'hF0, 8'hCC, sweep_exp[i]);
    chk("sweep_count", 32'(issue_count), 8);

    // ptr is 3 now; only requester 0 valid.
    set_req(0, 3'd2, 8'h0F, 8'hFF);
    set_req(1, 3'd0, 8'hAA, 8'h0F);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("sparse_grant", 32'(req_ready), 32'h1);
    push(2'd0, 8'hF0);
    @(posedge clk);
    #1;
    req_valid = 4'b0011;
    @(negedge clk);
    chk("sparse_ptr", 32'(req_ready), 32'h2);
    push(2'd1, 8'h0A);
    @(posedge clk);
    #1;
    req_valid = '0;
    out_ready = 1'b0;

    // Asynchronous reset mid-cycle with a pending result.
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    sb_q.delete();
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data", 32'(out_data), 0);
    chk("arst_tag", 32'(out_tag), 0);
    chk("arst_count", 32'(issue_count), 0);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("arst_ready", 32'(req_ready), 0);
    @(negedge clk);
    chk("arst_ready_hold", 32'(req_ready), 0);
    req_valid = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fairness with all four requesters held valid.
    for (int i = 0; i < 4; i++) set_req(i, 3'(i + 1), 8'(8'h11 * (i + 1)), 8'h5C);
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("fair_grant", 32'(req_ready), 32'(1) << fair_g[c]);
      push(2'(fair_g[c]), model(3'(fair_g[c] + 1), 8'(8'h11 * (fair_g[c] + 1)), 8'h5C));
      @(posedge clk);
      #1;
    end

    // Grant requester 0 from ptr=2 so ptr lands on 1 before backpressure.
    req_valid = 4'b0001;
    @(negedge clk);
    chk("bp_setup", 32'(req_ready), 32'h1);
    hold_data = model(3'd1, 8'h11, 8'h5C);
    push(2'd0, hold_data);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    req_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'(hold_data));
      chk("bp_tag", 32'(out_tag), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_refill", 32'(req_ready), 32'h2);
    push(2'd1, model(3'd2, 8'h22, 8'h5C));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_next", 32'(req_ready), 32'h8);
    push(2'd3, model(3'd4, 8'h44, 8'h5C));
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_sb", 32'(sb_q.size()), 0);

    // Counter saturation from a clean reset.
    rst = 1'b1;
    #2;
    sb_q.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;
    set_req(0, 3'd7, 8'h5A, 8'h00);
    req_valid = 4'b0001;
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      push(2'd0, 8'h5A);
      @(posedge clk);
    end
    #1;
    chk("sat_reach", 32'(issue_count), 32'hFFFF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      push(2'd0, 8'h5A);
      @(posedge clk);
    end
    #1;
    req_valid = '0;
    chk("sat_hold", 32'(issue_count), 32'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_sb", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bitop_rr_sched.md
Name: bitop_rr_sched

Overview:
- Round-robin scheduler that shares one registered bitwise-logic unit among NREQ requesters.
- The unit supports AND, OR, XOR, XNOR, NAND, NOR, ANDN and PASS.
- Each requester presents an opcode and two operands under a valid/ready handshake.
- The block grants one requester per cycle, computes the result, and holds it in a one-entry output register with the requester tag until the consumer accepts it.
- It sits between the per-lane issue logic and the shared logic-op datapath in synthesized test designs.

Parameters:
- WIDTH, 8, operand and result width in bits.
- NREQ, 4, number of requesters; fixed at 4 (tag is 2 bits).
- CNTW, 16, width of the issue counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_op  input  3*NREQ  opcode, requester i at bits [3i+2:3i].
- req_a  input  WIDTH*NREQ  operand A, requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i].
- req_b  input  WIDTH*NREQ  operand B, same packing as req_a.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- out_tag  output  2  index of the requester that produced out_data.
- issue_count  output  CNTW  number of accepted requests; saturating.

Behaviour:
- Reset, asynchronous, active-high. Outputs clear immediately on rst:
  - out_valid=0, out_data=0, out_tag=0, issue_count=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while rst is high.
- State machine, 2 states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
  - The FSM state is exactly out_valid.
- Accept condition: can_accept = !out_valid | out_ready. A FULL register that is drained this cycle may be refilled in the same cycle, so throughput is 1 per cycle under continuous out_ready.
- Arbitration (combinational):
  - When can_accept is high, grant the first i with req_valid[i]=1, searching ptr, ptr+1, … mod NREQ.
  - req_ready[grant]=1; all other req_ready bits are 0.
  - When no request is valid or can_accept=0, req_ready=0.
  - req_ready never depends on out_valid of the same cycle except through can_accept.
- On a transfer (req_valid[g] & req_ready[g]) at a clock edge:
  - out_data <= f(op_g, a_g, b_g).
  - out_tag <= g.
  - out_valid <= 1.
  - ptr <= (g+1) mod NREQ.
  - issue_count <= issue_count+1, saturating at all-ones.
- Opcode map, f(op, a, b):
  - 000: a&b
  - 001: a|b
  - 010: a^b
  - 011: ~(a^b)
  - 100: ~(a&b)
  - 101: ~(a|b)
  - 110: a&~b
  - 111: a
- Latency: exactly one cycle from the accepting edge to out_valid=1.
- Drain without refill: out_valid & out_ready with no transfer -> out_valid <= 0. out_data and out_tag hold their last values.
- Backpressure: out_valid & !out_ready -> out_data and out_tag are stable, req_ready=0, and ptr does not move.
- No transfer: ptr is unchanged, so the pointer advances only past granted requesters.
- Requester rules:
  - A requester must hold valid and payload stable until ready.
  - The block does not register request payloads before grant.
- Reset mid-operation: any pending result is discarded, with no partial output.
- Width rules: all logic ops are bitwise over WIDTH bits with no extension. The tag width is fixed at 2.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with out_valid=1 -> out_valid, out_data, out_tag and issue_count go to 0 immediately, and req_ready=0 during reset.
- Single op sweep, WIDTH=8, a=8'hF0, b=8'hCC, requester 2 only, out_ready=1, ops 000..111 -> out_data = C0, FC, 3C, C3, 3F, 03, 30, F0 respectively.
  - Each result appears one cycle after acceptance with out_tag=2.
  - issue_count=8 at the end.
- Fairness: all four req_valid held high, out_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, one transfer per cycle.
- Backpressure: result pending, out_ready=0 for 3 cycles with requests 1 and 3 valid -> req_ready=0, out_data and out_tag stable.
  - Then out_ready=1 -> the same cycle grants requester 1 (ptr=1) and refills with no bubble.
- Sparse pointer: ptr=3 with only requester 0 valid -> grant 0, and ptr becomes 1.
- Counter saturation: preload by running 65535 transfers, then 2 more -> issue_count stays 16'hFFFF.
